// File: rtl/sonata_pkg.sv
// Shared constants and types for the Sonata pin switch controller.
package sonata_pkg;

  localparam int unsigned INOUT_PIN_NUM = 64;

  localparam int unsigned PIN_SRC_NUM = 4;
  localparam int unsigned PIN_SEL_W   = $clog2(PIN_SRC_NUM);
  localparam int unsigned PIN_IDX_W   = $clog2(INOUT_PIN_NUM);

  typedef logic [PIN_SEL_W-1:0] pin_sel_t;
  typedef logic [PIN_IDX_W-1:0] pin_idx_t;

  // Cycles a pin's gate is held low before its select is rewritten.
  localparam int unsigned PIN_SWITCH_DEAD_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    GATE,
    SWITCH,
    RELEASE
  } pin_switch_state_e;

endpackage

// File: rtl/sonata_pin_switch_ctrl.sv
// Per-pin source-select table with glitch-free switchover: the pin's gate is
// dropped for a dead time, the select is rewritten, then the gate is released.
// One request is in flight at a time.
module sonata_pin_switch_ctrl
  import sonata_pkg::*;
#(
  parameter int unsigned NumPins    = INOUT_PIN_NUM,
  parameter int unsigned NumSrc     = PIN_SRC_NUM,
  parameter int unsigned DeadCycles = PIN_SWITCH_DEAD_CYCLES
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [$clog2(NumPins)-1:0]           req_pin_i,
  input  logic [$clog2(NumSrc)-1:0]            req_sel_i,
  input  logic                                 req_lock_i,
  output logic                                 done_valid_o,
  output logic                                 done_err_o,
  output logic [NumPins*$clog2(NumSrc)-1:0]    pin_sel_o,
  output logic [NumPins-1:0]                   pin_gate_o,
  output logic                                 busy_o
);

  localparam int unsigned SelW = $clog2(NumSrc);
  localparam int unsigned IdxW = $clog2(NumPins);
  localparam int unsigned CntW = $clog2(DeadCycles + 1);

  pin_switch_state_e r_state;
  pin_switch_state_e w_state_nxt;

  logic [IdxW-1:0]         r_pin;
  logic [SelW-1:0]         r_sel_req;
  logic                    r_lock_req;
  logic [NumPins*SelW-1:0] r_sel_tab;
  logic [NumPins-1:0]      r_gate;
  logic [NumPins-1:0]      r_lock;
  logic [CntW-1:0]         r_cnt;
  logic                    r_done_valid;
  logic                    r_done_err;

  logic            w_accept;
  logic            w_pin_bad;
  logic [SelW-1:0] w_cur_sel;
  logic            w_gate_clr;
  logic            w_gate_set;
  logic            w_sel_wr;
  logic            w_lock_set;
  logic            w_done;
  logic            w_done_err;
  logic            w_cnt_load;
  logic            w_cnt_dec;

  assign w_accept  = req_valid_i && (r_state == IDLE);
  // An out-of-range index is rejected before the lock bit is consulted.
  assign w_pin_bad = (32'(r_pin) >= NumPins) || r_lock[r_pin];
  assign w_cur_sel = r_sel_tab[r_pin*SelW +: SelW];

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and one-cycle update strobes for the table, gate and locks.
  always_comb begin
    w_state_nxt = r_state;
    w_gate_clr  = 1'b0;
    w_gate_set  = 1'b0;
    w_sel_wr    = 1'b0;
    w_lock_set  = 1'b0;
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid_i) w_state_nxt = CHECK;
      end
      CHECK: begin
        if (w_pin_bad) begin
          w_done      = 1'b1;
          w_done_err  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_cur_sel == r_sel_req) begin
          w_done      = 1'b1;
          w_lock_set  = r_lock_req;
          w_state_nxt = IDLE;
        end else begin
          w_gate_clr  = 1'b1;
          w_cnt_load  = 1'b1;
          // SWITCH itself supplies the last dead cycle, so a dead time of one
          // skips the GATE wait entirely.
          w_state_nxt = (DeadCycles > 1) ? GATE : SWITCH;
        end
      end
      GATE: begin
        w_cnt_dec = 1'b1;
        if (r_cnt == CntW'(1)) w_state_nxt = SWITCH;
      end
      SWITCH: begin
        w_sel_wr    = 1'b1;
        w_state_nxt = RELEASE;
      end
      RELEASE: begin
        w_gate_set  = 1'b1;
        w_done      = 1'b1;
        w_lock_set  = r_lock_req;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request capture; held stable until the controller returns to IDLE.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_pin      <= req_pin_i;
      r_sel_req  <= req_sel_i;
      r_lock_req <= req_lock_i;
    end
  end

  // Dead-time counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_cnt_load) begin
      r_cnt <= CntW'(DeadCycles - 1);
    end else if (w_cnt_dec) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  // Select table, gates and sticky locks; only the captured pin is touched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel_tab <= '0;
      r_gate    <= '1;
      r_lock    <= '0;
    end else begin
      if (w_gate_clr) r_gate[r_pin] <= 1'b0;
      if (w_gate_set) r_gate[r_pin] <= 1'b1;
      if (w_sel_wr)   r_sel_tab[r_pin*SelW +: SelW] <= r_sel_req;
      if (w_lock_set) r_lock[r_pin] <= 1'b1;
    end
  end

  // Registered single-cycle completion pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
    end else begin
      r_done_valid <= w_done;
      r_done_err   <= w_done_err;
    end
  end

  assign req_ready_o  = (r_state == IDLE);
  assign busy_o       = (r_state != IDLE);
  assign done_valid_o = r_done_valid;
  assign done_err_o   = r_done_err;
  assign pin_sel_o    = r_sel_tab;
  assign pin_gate_o   = r_gate;

endmodule

// File: tb/tb_sonata_pin_switch_ctrl.sv
// Bench for sonata_pin_switch_ctrl: completion pulses are matched against a
// queue of expected (cycle, error) entries; pin gate/select timing is checked
// cycle by cycle.
module tb_sonata_pin_switch_ctrl;
  import sonata_pkg::*;

  localparam int NP = INOUT_PIN_NUM;
  localparam int SW = PIN_SEL_W;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  pin_idx_t             req_pin_i;
  pin_sel_t             req_sel_i;
  logic                 req_lock_i;
  logic                 done_valid_o;
  logic                 done_err_o;
  logic [NP*SW-1:0]     pin_sel_o;
  logic [NP-1:0]        pin_gate_o;
  logic                 busy_o;

  sonata_pin_switch_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_pin_i    (req_pin_i),
    .req_sel_i    (req_sel_i),
    .req_lock_i   (req_lock_i),
    .done_valid_o (done_valid_o),
    .done_err_o   (done_err_o),
    .pin_sel_o    (pin_sel_o),
    .pin_gate_o   (pin_gate_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [SW-1:0] sel_of(input int p);
    return pin_sel_o[p*SW +: SW];
  endfunction

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!done_valid_o) begin
      chk("err_qual", done_err_o, 1'b0);
    end else if (sb.size() == 0) begin
      chk("unexp_done", 1'b1, 1'b0);
    end else begin
      mon_e = sb.pop_front();
      chk("done_cyc", cyc, mon_e.cyc);
      chk("done_err", done_err_o, mon_e.err);
    end
  end

  // Drive a request from just after a posedge, wait for acceptance, and
  // record the completion expected `lat` cycles later. Returns in cycle t+1.
  task automatic send(input int pin, input int sel, input bit lock,
                      input bit err, input int lat, output int t);
    bit ok;
    req_valid_i = 1'b1;
    req_pin_i   = PIN_IDX_W'(pin);
    req_sel_i   = PIN_SEL_W'(sel);
    req_lock_i  = lock;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1'b1);
    t = cyc;
    sb.push_back('{cyc: t + lat, err: err});
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_lock_i  = 1'b0;
  endtask

  int t, t2, k;
  logic [NP-1:0]    gate0, gmask;
  logic [NP*SW-1:0] sel0, smask;
  bit drained;

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_pin_i   = '0;
    req_sel_i   = '0;
    req_lock_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state.
    @(negedge clk_i);
    chk("rst_sel", pin_sel_o, '0);
    chk("rst_gate", pin_gate_o, {NP{1'b1}});
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);

    // Switch pin 18 to source 2: exact gate/select timing, no other pin moves.
    @(posedge clk_i); #1;
    gate0 = pin_gate_o;
    sel0  = pin_sel_o;
    gmask = '0;
    gmask[18] = 1'b1;
    smask = '0;
    smask[18*SW +: SW] = '1;
    send(18, 2, 1'b0, 1'b0, 7, t);
    repeat (8) begin
      @(negedge clk_i);
      k = cyc - t;
      chk("p18_gate", pin_gate_o[18], !(k >= 2 && k <= 6));
      chk("p18_sel", sel_of(18), (k >= 6) ? 2'd2 : 2'd0);
      chk("p18_busy", busy_o, (k <= 6));
      chk("oth_gate", pin_gate_o & ~gmask, gate0 & ~gmask);
      chk("oth_sel", pin_sel_o & ~smask, sel0 & ~smask);
    end

    // Same request again: no-op completion two cycles after accept.
    @(posedge clk_i); #1;
    send(18, 2, 1'b0, 1'b0, 2, t);
    repeat (4) begin
      @(negedge clk_i);
      chk("noop_gate", pin_gate_o[18], 1'b1);
      chk("noop_sel", sel_of(18), 2'd2);
    end

    // Lock pin 0 at source 1, then a further request on it is rejected.
    @(posedge clk_i); #1;
    send(0, 1, 1'b1, 1'b0, 7, t);
    @(posedge clk_i); #1;
    send(0, 3, 1'b0, 1'b1, 2, t);
    repeat (6) begin
      @(negedge clk_i);
      chk("lock_sel", sel_of(0), 2'd1);
      chk("lock_gate", pin_gate_o[0], 1'b1);
    end

    // Hold valid through a switch while req_sel_i wanders; only the value
    // present when ready returns is taken as the next request.
    @(posedge clk_i); #1;
    req_valid_i = 1'b1;
    req_pin_i   = 6'd7;
    req_sel_i   = 2'd1;
    req_lock_i  = 1'b0;
    @(negedge clk_i);
    chk("hold_acc_ready", req_ready_o, 1'b1);
    t = cyc;
    sb.push_back('{cyc: t + 7, err: 1'b0});
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk_i); #1;
      req_sel_i = 2'($urandom_range(3, 0));
      @(negedge clk_i);
      chk("hold_ready", req_ready_o, 1'b0);
    end
    @(posedge clk_i); #1;
    req_pin_i = 6'd9;
    req_sel_i = 2'd3;
    @(negedge clk_i);
    chk("b2b_ready", req_ready_o, 1'b1);
    t2 = cyc;
    chk("b2b_cyc", t2, t + 7);
    sb.push_back('{cyc: t2 + 7, err: 1'b0});
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("hold_sel7", sel_of(7), 2'd1);
    chk("hold_sel9", sel_of(9), 2'd3);

    // Reset in the middle of the GATE phase for pin 5.
    @(posedge clk_i); #1;
    send(5, 3, 1'b0, 1'b0, 7, t);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("gate5_low", pin_gate_o[5], 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    sb.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_gate5", pin_gate_o[5], 1'b1);
    chk("abort_sel5", sel_of(5), 2'd0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_ready", req_ready_o, 1'b1);
    chk("abort_gate_all", pin_gate_o, {NP{1'b1}});
    chk("abort_sel_all", pin_sel_o, '0);
    repeat (10) @(negedge clk_i);

    // Locks are cleared by reset: pin 0 can be switched again.
    @(posedge clk_i); #1;
    send(0, 3, 1'b0, 1'b0, 7, t);
    repeat (7) @(negedge clk_i);
    chk("unlock_sel0", sel_of(0), 2'd3);
    chk("unlock_gate0", pin_gate_o[0], 1'b1);

    drained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) begin
        drained = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    chk("sb_drain", drained, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
